// File: rtl/vertex_bram_min_update_single.sv
// Per-core apply stage: buffers vertex updates, does a read-modify-write min() on the vertex BRAM,
// emits improved vertices and retires iteration-end markers with an improvement count once drained.
module vertex_bram_min_update_single #(
  parameter int V_OFF_AWIDTH    = 8,
  parameter int V_VALUE_WIDTH   = 32,
  parameter int ITERATION_WIDTH = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int FULL_MARGIN     = 3,
  parameter int CNT_WIDTH       = V_OFF_AWIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [V_OFF_AWIDTH-1:0]    in_addr,
  input  logic [V_VALUE_WIDTH-1:0]   in_data,
  input  logic                       in_valid,
  input  logic                       in_iteration_end,
  input  logic                       in_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0] in_iteration_id,
  input  logic                       next_stage_full,
  output logic                       stage_full,
  output logic                       bram_rd_en,
  output logic [V_OFF_AWIDTH-1:0]    bram_rd_addr,
  input  logic [V_VALUE_WIDTH-1:0]   bram_rd_data,
  output logic                       bram_wr_en,
  output logic [V_OFF_AWIDTH-1:0]    bram_wr_addr,
  output logic [V_VALUE_WIDTH-1:0]   bram_wr_data,
  output logic [V_OFF_AWIDTH-1:0]    active_v_addr,
  output logic                       active_v_valid,
  output logic                       iteration_done,
  output logic [ITERATION_WIDTH-1:0] done_iteration_id,
  output logic [CNT_WIDTH-1:0]       done_update_count,
  output logic                       overflow_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  // Input FIFO storage (no reset needed; occupancy qualifies contents)
  logic [V_OFF_AWIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [V_VALUE_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             stage_full_q, stage_full_d;
  logic             overflow_q, overflow_d;

  logic                     p2_valid_q, p2_valid_d;
  logic [V_OFF_AWIDTH-1:0]  p2_addr_q, p2_addr_d;
  logic [V_VALUE_WIDTH-1:0] p2_data_q, p2_data_d;

  logic                     fwd_valid_q, fwd_valid_d;
  logic [V_OFF_AWIDTH-1:0]  fwd_addr_q, fwd_addr_d;
  logic [V_VALUE_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       pending_end_q, pending_end_d;
  logic [ITERATION_WIDTH-1:0] iter_id_q, iter_id_d;
  logic                       done_q, done_d;
  logic [ITERATION_WIDTH-1:0] done_id_q, done_id_d;
  logic [CNT_WIDTH-1:0]       done_cnt_q, done_cnt_d;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     push;
  logic                     pop;
  logic                     end_taken;
  logic                     retire;
  logic                     improve;
  logic [V_VALUE_WIDTH-1:0] old_value;

  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
    push       = in_valid && !fifo_full && !rst;
    pop        = !fifo_empty && !next_stage_full && !rst;
    end_taken  = in_iteration_end && in_iteration_end_valid;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q + {{(OCC_W-1){1'b0}}, push} - {{(OCC_W-1){1'b0}}, pop};
    stage_full_d = (occ_d >= OCC_W'(FIFO_DEPTH - FULL_MARGIN));
    overflow_d   = overflow_q || (in_valid && fifo_full);

    p2_valid_d = pop;
    p2_addr_d  = fifo_addr_q[rd_ptr_q];
    p2_data_d  = fifo_data_q[rd_ptr_q];

    // A write issued last cycle is not yet visible in a read-first BRAM read, so bypass it
    old_value = (fwd_valid_q && (fwd_addr_q == p2_addr_q)) ? fwd_data_q : bram_rd_data;
    improve   = p2_valid_q && (p2_data_q < old_value) && !rst;

    fwd_valid_d = improve;
    fwd_addr_d  = p2_addr_q;
    fwd_data_d  = p2_data_q;

    retire = pending_end_q && fifo_empty && !p2_valid_q && !in_valid;

    cnt_d = cnt_q;
    if (improve && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    if (retire) cnt_d = '0;

    pending_end_d = pending_end_q;
    if (retire) pending_end_d = 1'b0;
    if (end_taken) pending_end_d = 1'b1;
    iter_id_d = end_taken ? in_iteration_id : iter_id_q;

    done_d     = retire;
    done_id_d  = retire ? iter_id_q : done_id_q;
    done_cnt_d = retire ? cnt_q : done_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= in_addr;
      fifo_data_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      stage_full_q  <= 1'b0;
      overflow_q    <= 1'b0;
      p2_valid_q    <= 1'b0;
      p2_addr_q     <= '0;
      p2_data_q     <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_addr_q    <= '0;
      fwd_data_q    <= '0;
      cnt_q         <= '0;
      pending_end_q <= 1'b0;
      iter_id_q     <= '0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      done_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      stage_full_q  <= stage_full_d;
      overflow_q    <= overflow_d;
      p2_valid_q    <= p2_valid_d;
      p2_addr_q     <= p2_addr_d;
      p2_data_q     <= p2_data_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_addr_q    <= fwd_addr_d;
      fwd_data_q    <= fwd_data_d;
      cnt_q         <= cnt_d;
      pending_end_q <= pending_end_d;
      iter_id_q     <= iter_id_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  always_comb begin
    stage_full        = stage_full_q;
    overflow_err      = overflow_q;
    bram_rd_en        = pop;
    bram_rd_addr      = pop ? fifo_addr_q[rd_ptr_q] : '0;
    bram_wr_en        = improve;
    bram_wr_addr      = improve ? p2_addr_q : '0;
    bram_wr_data      = improve ? p2_data_q : '0;
    active_v_valid    = improve;
    active_v_addr     = improve ? p2_addr_q : '0;
    iteration_done    = done_q;
    done_iteration_id = done_id_q;
    done_update_count = done_cnt_q;
  end

endmodule

// File: tb/tb_vertex_bram_min_update_single.sv
// Directed bench for vertex_bram_min_update_single with a read-first BRAM model and a write scoreboard.
module tb_vertex_bram_min_update_single;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int CW = AW + 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_iteration_end;
  logic          in_iteration_end_valid;
  logic [IW-1:0] in_iteration_id;
  logic          next_stage_full;
  logic          stage_full;
  logic          bram_rd_en;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_wr_data;
  logic [AW-1:0] active_v_addr;
  logic          active_v_valid;
  logic          iteration_done;
  logic [IW-1:0] done_iteration_id;
  logic [CW-1:0] done_update_count;
  logic          overflow_err;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];

  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] mon_e;
  int               n_pass = 0;
  int               n_fail = 0;
  int               n_total = 0;
  bit               mon_en = 1'b0;
  int               done_pulses = 0;
  logic [IW-1:0]    last_done_id;
  logic [CW-1:0]    last_done_cnt;

  vertex_bram_min_update_single #(
    .V_OFF_AWIDTH(AW), .V_VALUE_WIDTH(DW), .ITERATION_WIDTH(IW),
    .FIFO_DEPTH(8), .FULL_MARGIN(3), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
    .in_iteration_end(in_iteration_end), .in_iteration_end_valid(in_iteration_end_valid),
    .in_iteration_id(in_iteration_id), .next_stage_full(next_stage_full),
    .stage_full(stage_full),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .active_v_addr(active_v_addr), .active_v_valid(active_v_valid),
    .iteration_done(iteration_done), .done_iteration_id(done_iteration_id),
    .done_update_count(done_update_count), .overflow_err(overflow_err)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Read-first synchronous BRAM model with a preload port
  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every BRAM write must match the next expected improvement
  always @(negedge clk) begin
    if (iteration_done) begin
      done_pulses++;
      last_done_id  = done_iteration_id;
      last_done_cnt = done_update_count;
    end
    if (mon_en) begin
      if (bram_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'(bram_wr_en), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr", 64'({bram_wr_addr, bram_wr_data}), 64'(mon_e));
          chk("active", 64'({active_v_valid, active_v_addr}), 64'({1'b1, mon_e[AW+DW-1:DW]}));
        end
      end else begin
        chk("active_idle", 64'(active_v_valid), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (acc && (d < ref_mem[a])) begin
      exp_q.push_back({a, d});
      ref_mem[a] = d;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_iteration_end = 1'b0;
    in_iteration_end_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [IW-1:0] eid, input logic [CW-1:0] ecnt);
    int start;
    bit seen;
    start = done_pulses;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_pulses != start) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({tag, "_id"}, 64'(last_done_id), 64'(eid));
      chk({tag, "_cnt"}, 64'(last_done_cnt), 64'(ecnt));
    end
    repeat (5) step();
    chk({tag, "_one_pulse"}, 64'(done_pulses), 64'(start + 1));
  endtask

  initial begin
    int pulses0;
    rst = 1'b1;
    next_stage_full = 1'b0;
    in_iteration_id = '0;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    idle();
    for (int a = 0; a < 256; a++) begin
      step();
      pre_en = 1'b1;
      pre_addr = 8'(a);
      pre_data = '1;
      ref_mem[a] = '1;
    end
    step();
    pre_en = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stage_full", 64'(stage_full), 64'(0));
    chk("rst_rd_en", 64'(bram_rd_en), 64'(0));
    chk("rst_wr_en", 64'(bram_wr_en), 64'(0));
    chk("rst_done", 64'(iteration_done), 64'(0));
    chk("rst_done_cnt", 64'(done_update_count), 64'(0));
    chk("rst_overflow", 64'(overflow_err), 64'(0));
    mon_en = 1'b1;

    // Single update: read at +1, write/emit at +2
    step();
    drive(8'd5, 32'd10, 1'b1);
    @(negedge clk);
    chk("t1_rd_early", 64'(bram_rd_en), 64'(0));
    step();
    idle();
    @(negedge clk);
    chk("t1_rd_en", 64'(bram_rd_en), 64'(1));
    chk("t1_rd_addr", 64'(bram_rd_addr), 64'(5));
    chk("t1_wr_early", 64'(bram_wr_en), 64'(0));
    step();
    @(negedge clk);
    chk("t1_wr", 64'({bram_wr_en, bram_wr_addr, bram_wr_data}), 64'({1'b1, 8'd5, 32'd10}));
    chk("t1_active", 64'({active_v_valid, active_v_addr}), 64'({1'b1, 8'd5}));
    repeat (2) step();

    // Back-to-back same address: needs the forwarding path
    drive(8'd3, 32'd20, 1'b1);
    step();
    drive(8'd3, 32'd15, 1'b1);
    step();
    drive(8'd3, 32'd18, 1'b1);
    step();
    idle();
    repeat (5) step();
    chk("t2_mem3", 64'(mem[3]), 64'(15));
    chk("t2_drained", 64'(exp_q.size()), 64'(0));

    // Preloaded smaller value: no write
    pre_en = 1'b1;
    pre_addr = 8'd7;
    pre_data = 32'd4;
    ref_mem[7] = 32'd4;
    step();
    pre_en = 1'b0;
    drive(8'd7, 32'd9, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("t3_rd", 64'({bram_rd_en, bram_rd_addr}), 64'({1'b1, 8'd7}));
    step();
    @(negedge clk);
    chk("t3_no_wr", 64'({bram_wr_en, active_v_valid}), 64'(0));
    step();
    in_iteration_end = 1'b1;
    in_iteration_end_valid = 1'b1;
    in_iteration_id = 8'd1;
    step();
    idle();
    wait_done("t3_retire", 8'd1, 9'd3);

    // Three updates, two improving; marker shares the cycle with the last one
    drive(8'd10, 32'd50, 1'b1);
    step();
    drive(8'd11, 32'd60, 1'b1);
    step();
    drive(8'd7, 32'd8, 1'b1);
    in_iteration_end = 1'b1;
    in_iteration_end_valid = 1'b1;
    in_iteration_id = 8'd2;
    step();
    idle();
    wait_done("t4_retire", 8'd2, 9'd2);
    in_iteration_end = 1'b1;
    in_iteration_end_valid = 1'b1;
    in_iteration_id = 8'd3;
    step();
    idle();
    wait_done("t4_cleared", 8'd3, 9'd0);

    // End bit without its qualifier is ignored
    pulses0 = done_pulses;
    in_iteration_end = 1'b1;
    in_iteration_id = 8'd9;
    step();
    idle();
    repeat (6) step();
    chk("t4_unqualified_end", 64'(done_pulses), 64'(pulses0));

    // Backpressure, fill, overflow, drain
    next_stage_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      drive(8'(20 + i), 32'(100 + i), 1'b1);
      @(negedge clk);
      chk("t5_no_rd", 64'(bram_rd_en), 64'(0));
      chk("t5_stage_full", 64'(stage_full), 64'(i >= 5));
    end
    for (int i = 6; i < 9; i++) begin
      step();
      drive(8'(20 + i), 32'(100 + i), i < 8);
      @(negedge clk);
      chk("t5_ovf_early", 64'(overflow_err), 64'(0));
      chk("t5_full_hold", 64'(stage_full), 64'(1));
    end
    step();
    idle();
    @(negedge clk);
    chk("t5_overflow", 64'(overflow_err), 64'(1));
    chk("t5_no_rd_held", 64'(bram_rd_en), 64'(0));
    step();
    next_stage_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_drain_rd", 64'({bram_rd_en, bram_rd_addr}), 64'({1'b1, 8'(20 + i)}));
      step();
    end
    @(negedge clk);
    chk("t5_drain_end", 64'(bram_rd_en), 64'(0));
    repeat (4) step();
    chk("t5_stage_full_clr", 64'(stage_full), 64'(0));
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset with queued work and a pending end
    next_stage_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'(40 + i), 32'd1, 1'b0);
      if (i == 3) begin
        in_iteration_end = 1'b1;
        in_iteration_end_valid = 1'b1;
        in_iteration_id = 8'd5;
      end
      step();
    end
    idle();
    rst = 1'b1;
    pulses0 = done_pulses;
    @(negedge clk);
    chk("t6_rst_cycle_io", 64'({bram_rd_en, bram_wr_en}), 64'(0));
    step();
    rst = 1'b0;
    next_stage_full = 1'b0;
    @(negedge clk);
    chk("t6_stage_full", 64'(stage_full), 64'(0));
    chk("t6_overflow", 64'(overflow_err), 64'(0));
    chk("t6_done_id", 64'(done_iteration_id), 64'(0));
    chk("t6_outs", 64'({bram_rd_en, bram_wr_en, active_v_valid, iteration_done}), 64'(0));
    repeat (15) step();
    chk("t6_no_done", 64'(done_pulses), 64'(pulses0));
    chk("t6_mem40", 64'(mem[40]), 64'(32'hFFFF_FFFF));
    chk("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
